// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 18;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W,
  parameter int CTRL_W = pipe_pkg::DEF_CTRL_W
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register: main entry drives the outputs,
// skid entry absorbs the beat accepted in the cycle downstream stalls.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic            Clk,
  input  logic            Reset,
  pipe_stage_reg_if.slave bus
);

  state_e            r_state;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  state_e w_state;
  state_e w_next;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_fire;
  logic   w_ld_main_in;
  logic   w_ld_main_skid;
  logic   w_ld_skid;

  // Unused encoding 2'd3 is treated as EMPTY everywhere.
  always_comb begin
    w_state     = ((r_state == ONE) || (r_state == FULL)) ? r_state : EMPTY;
    w_in_ready  = (w_state != FULL);
    w_out_valid = (w_state != EMPTY);
    w_accept    = bus.in_valid & w_in_ready;
    w_fire      = w_out_valid & bus.out_ready;
  end

  always_comb begin
    w_next         = w_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (w_state)
      EMPTY: begin
        if (w_accept) begin
          w_next       = ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_accept) begin
          w_next    = FULL;
          w_ld_skid = 1'b1;
        end else if (w_fire) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        if (w_fire) begin
          w_next         = ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
    // Flush drops the incoming beat; a simultaneous fire has already been consumed downstream.
    if (bus.flush) begin
      w_next         = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= EMPTY;
      r_occ   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_occ   <= occ_of(w_next);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_data <= bus.in_data;
        r_main_ctrl <= bus.in_ctrl;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_ld_skid) begin
        r_skid_data <= bus.in_data;
        r_skid_ctrl <= bus.in_ctrl;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench driving three width variants of pipe_stage_reg in lockstep.
module tb_pipe_stage_reg;

  logic         Clk;
  logic         Reset;
  logic         tb_valid;
  logic [127:0] tb_data;
  logic [31:0]  tb_ctrl;
  logic         tb_flush;
  logic         tb_oready;

  int n_tests;
  int n_fail;

  pipe_stage_reg_if #(.DATA_W(96),  .CTRL_W(18)) b0 ();
  pipe_stage_reg_if #(.DATA_W(8),   .CTRL_W(1))  b1 ();
  pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(32)) b2 ();

  pipe_stage_reg #(.DATA_W(96),  .CTRL_W(18)) u0 (.Clk(Clk), .Reset(Reset), .bus(b0));
  pipe_stage_reg #(.DATA_W(8),   .CTRL_W(1))  u1 (.Clk(Clk), .Reset(Reset), .bus(b1));
  pipe_stage_reg #(.DATA_W(128), .CTRL_W(32)) u2 (.Clk(Clk), .Reset(Reset), .bus(b2));

  assign b0.in_valid = tb_valid;  assign b1.in_valid = tb_valid;  assign b2.in_valid = tb_valid;
  assign b0.in_data  = tb_data[95:0];
  assign b1.in_data  = tb_data[7:0];
  assign b2.in_data  = tb_data;
  assign b0.in_ctrl  = tb_ctrl[17:0];
  assign b1.in_ctrl  = tb_ctrl[0];
  assign b2.in_ctrl  = tb_ctrl;
  assign b0.flush = tb_flush;     assign b1.flush = tb_flush;     assign b2.flush = tb_flush;
  assign b0.out_ready = tb_oready; assign b1.out_ready = tb_oready; assign b2.out_ready = tb_oready;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] msk(input int unsigned w);
    logic [127:0] m;
    m = '1;
    if (w < 128) m = (128'd1 << w) - 128'd1;
    return m;
  endfunction

  task automatic check_all(input string tag, input logic v, input logic [127:0] d,
                           input logic [31:0] c, input logic [1:0] occ, input logic rdy);
    check({tag, "/u0.valid"}, 128'(b0.out_valid), 128'(v));
    check({tag, "/u0.ready"}, 128'(b0.in_ready),  128'(rdy));
    check({tag, "/u0.occ"},   128'(b0.occupancy), 128'(occ));
    check({tag, "/u0.data"},  128'(b0.out_data),  d & msk(96));
    check({tag, "/u0.ctrl"},  128'(b0.out_ctrl),  128'(c) & msk(18));
    check({tag, "/u1.valid"}, 128'(b1.out_valid), 128'(v));
    check({tag, "/u1.ready"}, 128'(b1.in_ready),  128'(rdy));
    check({tag, "/u1.occ"},   128'(b1.occupancy), 128'(occ));
    check({tag, "/u1.data"},  128'(b1.out_data),  d & msk(8));
    check({tag, "/u1.ctrl"},  128'(b1.out_ctrl),  128'(c) & msk(1));
    check({tag, "/u2.valid"}, 128'(b2.out_valid), 128'(v));
    check({tag, "/u2.ready"}, 128'(b2.in_ready),  128'(rdy));
    check({tag, "/u2.occ"},   128'(b2.occupancy), 128'(occ));
    check({tag, "/u2.data"},  b2.out_data,        d);
    check({tag, "/u2.ctrl"},  128'(b2.out_ctrl),  128'(c));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [31:0] c);
    tb_valid = v;
    tb_data  = d;
    tb_ctrl  = c;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    Reset     = 1'b1;
    tb_flush  = 1'b0;
    tb_oready = 1'b0;
    drive(1'b0, '0, '0);
    #2;
    check_all("reset", 1'b0, '0, '0, 2'd0, 1'b1);
    tick();
    Reset = 1'b0;

    // Streaming: first accept lands on the first edge after reset release.
    tb_oready = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(1'b1, 128'(i), 32'(i + 16));
      tick();
      check_all($sformatf("stream%0d", i), 1'b1, 128'(i), 32'(i + 16), 2'd1, 1'b1);
    end
    drive(1'b0, '0, '0);
    tick();
    check_all("drain", 1'b0, 128'd4, '0, 2'd0, 1'b1);

    // Backpressure
    tb_oready = 1'b0;
    drive(1'b1, 128'hA, 32'h2A);
    tick();
    check_all("bp_a", 1'b1, 128'hA, 32'h2A, 2'd1, 1'b1);
    drive(1'b1, 128'hB, 32'h2B);
    tick();
    check_all("bp_full", 1'b1, 128'hA, 32'h2A, 2'd2, 1'b0);
    drive(1'b0, '0, '0);
    tick();
    check_all("bp_hold", 1'b1, 128'hA, 32'h2A, 2'd2, 1'b0);
    tb_oready = 1'b1;
    tick();
    check_all("bp_out_b", 1'b1, 128'hB, 32'h2B, 2'd1, 1'b1);
    tick();
    check_all("bp_empty", 1'b0, 128'hB, '0, 2'd0, 1'b1);

    // Flush while FULL, held for three cycles with an offered beat
    tb_oready = 1'b0;
    drive(1'b1, 128'hA, 32'h2A);
    tick();
    drive(1'b1, 128'hB, 32'h2B);
    tick();
    check_all("fl_pre", 1'b1, 128'hA, 32'h2A, 2'd2, 1'b0);
    drive(1'b1, 128'hC, 32'h2C);
    tb_flush = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("flush%0d", i), 1'b0, 128'hA, '0, 2'd0, 1'b1);
    end
    tb_flush  = 1'b0;
    tb_oready = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    check_all("fl_after", 1'b0, 128'hA, '0, 2'd0, 1'b1);

    // Bubble with all control bits set on the input
    drive(1'b0, '0, 32'hFFFF_FFFF);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("bubble%0d", i), 1'b0, 128'hA, '0, 2'd0, 1'b1);
    end

    // Asynchronous reset with two beats held
    tb_oready = 1'b0;
    drive(1'b1, 128'h5, 32'h15);
    tick();
    drive(1'b1, 128'h6, 32'h16);
    tick();
    check_all("rm_pre", 1'b1, 128'h5, 32'h15, 2'd2, 1'b0);
    Reset = 1'b1;
    #1;
    check_all("rm_async", 1'b0, '0, '0, 2'd0, 1'b1);
    tick();
    check_all("rm_held", 1'b0, '0, '0, 2'd0, 1'b1);
    Reset = 1'b0;
    drive(1'b1, 128'h7, 32'h17);
    tick();
    check_all("rm_first", 1'b1, 128'h7, 32'h17, 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
